// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit: resolves conditional branches into a one-deep output register, with statistics.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             branch_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             br_taken_o,
  output logic [XLEN-1:0]  target_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             mispredict_o,
  output logic             illegal_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             out_valid_q;
  logic             br_taken_q, br_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             illegal_q, illegal_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic cmp_eq, cmp_lt, cmp_ltu, accept;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  assign cmp_eq  = (rs1_i == rs2_i);
  assign cmp_lt  = ($signed(rs1_i) < $signed(rs2_i));
  assign cmp_ltu = (rs1_i < rs2_i);

  always_comb begin
    br_taken_d = 1'b0;
    illegal_d  = 1'b0;
    if (branch_i) begin
      case (funct3_i)
        3'b000:  br_taken_d = cmp_eq;
        3'b001:  br_taken_d = !cmp_eq;
        3'b100:  br_taken_d = cmp_lt;
        3'b101:  br_taken_d = !cmp_lt;
        3'b110:  br_taken_d = cmp_ltu;
        3'b111:  br_taken_d = !cmp_ltu;
        default: illegal_d  = 1'b1;
      endcase
    end
    target_d     = pc_i + imm_i;
    redirect_d   = br_taken_d ? target_d : (pc_i + PC_STEP);
    mispredict_d = branch_i && (br_taken_d ^ pred_taken_i);
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (clr_cnt_i) begin
      taken_cnt_d   = '0;
      mispred_cnt_d = '0;
    end else if (accept) begin
      if (br_taken_d && (taken_cnt_q != CNT_MAX))
        taken_cnt_d = taken_cnt_q + CNT_ONE;
      if (mispredict_d && (mispred_cnt_q != CNT_MAX))
        mispred_cnt_d = mispred_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      br_taken_q    <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      target_q      <= '0;
      redirect_q    <= '0;
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (accept) begin
        out_valid_q  <= 1'b1;
        br_taken_q   <= br_taken_d;
        mispredict_q <= mispredict_d;
        illegal_q    <= illegal_d;
        target_q     <= target_d;
        redirect_q   <= redirect_d;
      end else if (out_ready_i) begin
        out_valid_q  <= 1'b0;
      end
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign br_taken_o    = br_taken_q;
  assign mispredict_o  = mispredict_q;
  assign illegal_o     = illegal_q;
  assign target_o      = target_q;
  assign redirect_pc_o = redirect_q;
  assign taken_cnt_o   = taken_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

`default_nettype wire
